// File: rtl/morse_char_assembler_if.sv
// Symbol-in / character-out bundle of the Morse character assembler.
// master is the assembler side, slave is the classifier/decoder side.
interface morse_char_assembler_if #(
  parameter int MAX_SYMBOLS = 5
);
  logic [1:0]             sym_in;
  logic                   key_down;
  logic                   out_ready;
  logic                   out_valid;
  logic [MAX_SYMBOLS-1:0] out_code;
  logic [2:0]             out_len;
  logic                   out_word_end;
  logic                   out_overflow;
  logic                   drop_pulse;

  modport master (
    input  sym_in,
    input  key_down,
    input  out_ready,
    output out_valid,
    output out_code,
    output out_len,
    output out_word_end,
    output out_overflow,
    output drop_pulse
  );

  modport slave (
    output sym_in,
    output key_down,
    output out_ready,
    input  out_valid,
    input  out_code,
    input  out_len,
    input  out_word_end,
    input  out_overflow,
    input  drop_pulse
  );
endinterface

// File: rtl/morse_char_assembler.sv
// Builds dot/dash codes into characters, closes them on gap or send,
// and holds one finished character in an output register.
module morse_char_assembler #(
  parameter int MAX_SYMBOLS = 5,
  parameter int GAP_CYCLES  = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  morse_char_assembler_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_STALL   = 2'd2;

  localparam logic [2:0]  MAX_LEN  = 3'(MAX_SYMBOLS);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [MAX_SYMBOLS-1:0] asm_code_q, asm_code_d;
  logic [2:0]             asm_len_q, asm_len_d;
  logic                   asm_ovf_q, asm_ovf_d;
  logic [15:0]            gap_cnt_q, gap_cnt_d;
  logic                   send_prev_q, send_prev_d;
  logic                   pend_we_q, pend_we_d;

  logic                   out_valid_q, out_valid_d;
  logic [MAX_SYMBOLS-1:0] out_code_q, out_code_d;
  logic [2:0]             out_len_q, out_len_d;
  logic                   out_we_q, out_we_d;
  logic                   out_ovf_q, out_ovf_d;
  logic                   drop_q, drop_d;

  logic                   is_sym;
  logic                   send_ev;
  logic                   idle_cnt;
  logic                   xfer;
  logic                   can_load;
  logic [MAX_SYMBOLS-1:0] sym_onehot;

  logic close, close_we;
  logic load, load_we;

  always_comb begin
    is_sym   = (bus.sym_in == 2'b01) ||
               (bus.sym_in == 2'b10);
    send_ev  = (bus.sym_in == 2'b11) && !send_prev_q;
    idle_cnt = (bus.sym_in == 2'b00) && !bus.key_down;
    xfer     = out_valid_q && bus.out_ready;
    can_load = !out_valid_q || bus.out_ready;
    sym_onehot    = '0;
    sym_onehot[0] = bus.sym_in[1];
  end

  always_comb begin
    state_d     = state_q;
    asm_code_d  = asm_code_q;
    asm_len_d   = asm_len_q;
    asm_ovf_d   = asm_ovf_q;
    gap_cnt_d   = gap_cnt_q;
    pend_we_d   = pend_we_q;
    send_prev_d = (bus.sym_in == 2'b11);
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_len_d   = out_len_q;
    out_we_d    = out_we_q;
    out_ovf_d   = out_ovf_q;
    drop_d      = 1'b0;
    close       = 1'b0;
    close_we    = 1'b0;
    load        = 1'b0;
    load_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_sym: begin
            asm_code_d = sym_onehot;
            asm_len_d  = 3'd1;
            asm_ovf_d  = 1'b0;
            gap_cnt_d  = '0;
            state_d    = S_COLLECT;
          end
          send_ev: begin
            close    = 1'b1;
            close_we = 1'b1;
          end
          default: ;
        endcase
      end
      S_COLLECT: begin
        unique case (1'b1)
          is_sym: begin
            gap_cnt_d = '0;
            if (asm_len_q < MAX_LEN) begin
              asm_code_d = asm_code_q |
                           (sym_onehot << asm_len_q);
              asm_len_d  = asm_len_q + 3'd1;
            end else begin
              asm_ovf_d = 1'b1;
            end
          end
          send_ev: begin
            close    = 1'b1;
            close_we = 1'b1;
          end
          idle_cnt: begin
            // counter never passes GAP_LAST: reaching it closes
            if (gap_cnt_q >= GAP_LAST) begin
              close = 1'b1;
            end else begin
              gap_cnt_d = gap_cnt_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
      S_STALL: begin
        drop_d = is_sym;
        if (xfer) begin
          load    = 1'b1;
          load_we = pend_we_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (close) begin
      if (can_load) begin
        load    = 1'b1;
        load_we = close_we;
      end else begin
        state_d   = S_STALL;
        pend_we_d = close_we;
      end
    end

    // the finished character always lives in the asm_* registers
    if (load) begin
      out_valid_d = 1'b1;
      out_code_d  = asm_code_q;
      out_len_d   = asm_len_q;
      out_we_d    = load_we;
      out_ovf_d   = asm_ovf_q;
      asm_code_d  = '0;
      asm_len_d   = '0;
      asm_ovf_d   = 1'b0;
      gap_cnt_d   = '0;
      pend_we_d   = 1'b0;
      state_d     = S_IDLE;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      asm_code_q  <= '0;
      asm_len_q   <= '0;
      asm_ovf_q   <= 1'b0;
      gap_cnt_q   <= '0;
      send_prev_q <= 1'b0;
      pend_we_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_len_q   <= '0;
      out_we_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_code_q  <= asm_code_d;
      asm_len_q   <= asm_len_d;
      asm_ovf_q   <= asm_ovf_d;
      gap_cnt_q   <= gap_cnt_d;
      send_prev_q <= send_prev_d;
      pend_we_q   <= pend_we_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_len_q   <= out_len_d;
      out_we_q    <= out_we_d;
      out_ovf_q   <= out_ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_code     = out_code_q;
  assign bus.out_len      = out_len_q;
  assign bus.out_word_end = out_we_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.drop_pulse   = drop_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Bench for morse_char_assembler: vector table, reset sequence,
// and random traffic against a queue-based character model.
module tb_morse_char_assembler;

  localparam int MAXS = 5;
  localparam int GAP  = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;

  morse_char_assembler_if #(.MAX_SYMBOLS(MAXS)) bus ();

  morse_char_assembler #(
    .MAX_SYMBOLS(MAXS),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return 32'({bus.out_valid, bus.out_code, bus.out_len,
                bus.out_word_end, bus.out_overflow,
                bus.drop_pulse});
  endfunction

  function automatic logic [31:0] pack_exp(
    logic v, logic [4:0] c, logic [2:0] l,
    logic we, logic ov, logic dr);
    return 32'({v, c, l, we, ov, dr});
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int code;
    int len;
    bit we;
    bit ovf;
  } char_t;

  bit    m_in_char;
  bit    m_syms[$];
  bit    m_ovf;
  int    m_idle;
  bit    m_stalled;
  char_t m_pend;
  bit    m_valid;
  char_t m_out;
  bit    m_drop;
  bit    m_sp;

  function automatic char_t make_char(bit we);
    char_t c;
    c.code = 0;
    foreach (m_syms[i]) c.code += int'(m_syms[i]) << i;
    c.len = m_syms.size();
    c.ovf = m_ovf;
    c.we  = we;
    return c;
  endfunction

  function automatic void model_reset();
    m_in_char = 0;
    m_syms.delete();
    m_ovf     = 0;
    m_idle    = 0;
    m_stalled = 0;
    m_pend    = '{0, 0, 0, 0};
    m_valid   = 0;
    m_out     = '{0, 0, 0, 0};
    m_drop    = 0;
    m_sp      = 0;
  endfunction

  function automatic void model_step(logic [1:0] s,
                                     logic k, logic r);
    bit send_ev, is_sym, xfer, closing, load, drop_n;
    char_t c, ld;
    send_ev = (s == 2'b11) && !m_sp;
    m_sp    = (s == 2'b11);
    is_sym  = (s == 2'b01) || (s == 2'b10);
    xfer    = m_valid && r;
    closing = 0;
    load    = 0;
    drop_n  = 0;
    if (m_stalled) begin
      if (is_sym) drop_n = 1;
      if (xfer) begin
        load = 1;
        ld = m_pend;
        m_stalled = 0;
      end
    end else if (!m_in_char) begin
      if (is_sym) begin
        m_syms.delete();
        m_syms.push_back(s == 2'b10);
        m_in_char = 1;
        m_idle = 0;
        m_ovf = 0;
      end else if (send_ev) begin
        closing = 1;
        c = make_char(1);
      end
    end else begin
      if (is_sym) begin
        if (m_syms.size() < MAXS) m_syms.push_back(s == 2'b10);
        else m_ovf = 1;
        m_idle = 0;
      end else if (send_ev) begin
        closing = 1;
        c = make_char(1);
      end else if (s == 2'b00 && !k) begin
        m_idle++;
        if (m_idle == GAP) begin
          closing = 1;
          c = make_char(0);
        end
      end
    end
    if (closing) begin
      m_in_char = 0;
      m_syms.delete();
      m_ovf = 0;
      m_idle = 0;
      if (!m_valid || r) begin
        load = 1;
        ld = c;
      end else begin
        m_stalled = 1;
        m_pend = c;
      end
    end
    if (load) begin
      m_valid = 1;
      m_out = ld;
    end else if (xfer) begin
      m_valid = 0;
    end
    m_drop = drop_n;
  endfunction

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step(bus.sym_in, bus.key_down, bus.out_ready);
  end

  always @(negedge clk) begin
    if (!rst)
      chk("cycle_model", pack_out(),
          pack_exp(m_valid, 5'(m_out.code), 3'(m_out.len),
                   m_out.we, m_out.ovf, m_drop));
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [1:0] sym;
    logic       key;
    logic       rdy;
    int         n;
    logic [31:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic [1:0] s, logic k,
                              logic r, int n, logic v,
                              logic [4:0] c, logic [2:0] l,
                              logic we, logic ov, logic dr);
    vec_t x;
    x.nm  = nm;
    x.sym = s;
    x.key = k;
    x.rdy = r;
    x.n   = n;
    x.exp = pack_exp(v, c, l, we, ov, dr);
    return x;
  endfunction

  task automatic apply(input logic [1:0] s,
                       input logic k, input logic r);
    bus.sym_in    = s;
    bus.key_down  = k;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.sym_in    = 2'b00;
    bus.key_down  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", pack_out(), 32'd0);
    rst = 1'b0;

    // dot, dash, 60 idles
    tbl.push_back(mk("g_dot",    1, 0, 1,  1, 0, 5'b00000, 0, 0, 0, 0));
    tbl.push_back(mk("g_dash",   2, 0, 1,  1, 0, 5'b00000, 0, 0, 0, 0));
    tbl.push_back(mk("g_idle59", 0, 0, 1, 59, 0, 5'b00000, 0, 0, 0, 0));
    tbl.push_back(mk("g_close",  0, 0, 1,  1, 1, 5'b00010, 2, 0, 0, 0));
    tbl.push_back(mk("g_taken",  0, 0, 1,  1, 0, 5'b00010, 2, 0, 0, 0));
    // dash then held send
    tbl.push_back(mk("s_dash",   2, 0, 1,  1, 0, 5'b00010, 2, 0, 0, 0));
    tbl.push_back(mk("s_close",  3, 0, 1,  1, 1, 5'b00001, 1, 1, 0, 0));
    tbl.push_back(mk("s_held",   3, 0, 1,  9, 0, 5'b00001, 1, 1, 0, 0));
    tbl.push_back(mk("s_rel",    0, 0, 1,  1, 0, 5'b00001, 1, 1, 0, 0));
    // six dots: overflow
    tbl.push_back(mk("o_dots",   1, 0, 1,  6, 0, 5'b00001, 1, 1, 0, 0));
    tbl.push_back(mk("o_close",  0, 0, 1, 60, 1, 5'b00000, 5, 0, 1, 0));
    tbl.push_back(mk("o_taken",  0, 0, 1,  1, 0, 5'b00000, 5, 0, 1, 0));
    // key_down freezes the gap
    tbl.push_back(mk("k_dot",    1, 0, 1,  1, 0, 5'b00000, 5, 0, 1, 0));
    tbl.push_back(mk("k_hold",   0, 1, 1,100, 0, 5'b00000, 5, 0, 1, 0));
    tbl.push_back(mk("k_dash",   2, 0, 1,  1, 0, 5'b00000, 5, 0, 1, 0));
    tbl.push_back(mk("k_close",  0, 0, 1, 60, 1, 5'b00010, 2, 0, 0, 0));
    tbl.push_back(mk("k_taken",  0, 0, 1,  1, 0, 5'b00010, 2, 0, 0, 0));
    // A then T with downstream stalled
    tbl.push_back(mk("a_dot",    1, 0, 0,  1, 0, 5'b00010, 2, 0, 0, 0));
    tbl.push_back(mk("a_dash",   2, 0, 0,  1, 0, 5'b00010, 2, 0, 0, 0));
    tbl.push_back(mk("a_send",   3, 0, 0,  1, 1, 5'b00010, 2, 1, 0, 0));
    tbl.push_back(mk("a_wait",   0, 0, 0,  1, 1, 5'b00010, 2, 1, 0, 0));
    tbl.push_back(mk("t_dash",   2, 0, 0,  1, 1, 5'b00010, 2, 1, 0, 0));
    tbl.push_back(mk("t_send",   3, 0, 0,  1, 1, 5'b00010, 2, 1, 0, 0));
    tbl.push_back(mk("st_wait",  0, 0, 0,  3, 1, 5'b00010, 2, 1, 0, 0));
    tbl.push_back(mk("st_drop",  1, 0, 0,  1, 1, 5'b00010, 2, 1, 0, 1));
    tbl.push_back(mk("st_nodrp", 0, 0, 0,  1, 1, 5'b00010, 2, 1, 0, 0));
    tbl.push_back(mk("st_xfer",  0, 0, 1,  1, 1, 5'b00001, 1, 1, 0, 0));
    tbl.push_back(mk("st_done",  0, 0, 1,  1, 0, 5'b00001, 1, 1, 0, 0));

    foreach (tbl[i]) begin
      repeat (tbl[i].n) apply(tbl[i].sym, tbl[i].key, tbl[i].rdy);
      chk(tbl[i].nm, pack_out(), tbl[i].exp);
    end

    // reset mid-character with a character waiting
    apply(1, 0, 0);
    apply(3, 0, 0);
    chk("r_valid", 32'(bus.out_valid), 32'd1);
    apply(0, 0, 0);
    apply(1, 0, 0);
    apply(2, 0, 0);
    apply(1, 0, 0);
    rst = 1'b1;
    #1;
    chk("r_async", pack_out(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(1, 0, 1);
    apply(3, 0, 1);
    chk("r_fresh", pack_out(), pack_exp(1, 5'b00000, 1, 1, 0, 0));
    apply(0, 0, 1);
    apply(3, 0, 1);
    chk("empty_send", pack_out(), pack_exp(1, 5'b00000, 0, 1, 0, 0));
    apply(0, 0, 1);

    // random traffic, alternating dense and sparse phases
    begin
      int hold;
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
        logic [1:0] s;
        int p;
        bit dense;
        dense = ((i / 500) % 2) == 0;
        if (hold > 0) begin
          s = 2'b11;
          hold--;
        end else begin
          p = dense ? int'($urandom_range(0, 99))
                    : int'($urandom_range(0, 199));
          if (p < (dense ? 8 : 1))       s = 2'b01;
          else if (p < (dense ? 16 : 2)) s = 2'b10;
          else if (p < (dense ? 19 : 3)) s = 2'b11;
          else                           s = 2'b00;
          if (s == 2'b11) hold = int'($urandom_range(0, 4));
        end
        apply(s, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) != 0);
      end
    end

    apply(0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_char_assembler.md
# morse_char_assembler

Sequencing stage placed directly after the dot/dash timing classifier. Collects classified symbols into a per-character code, decides when a character is finished (inter-letter gap or send request), and presents completed characters to the downstream decoder/display over a valid/ready handshake. A one-entry output register lets assembly of the next character continue while the previous one waits for acceptance.

## Interface
- MAX_SYMBOLS, 5: symbols per character (range 1..7).
- GAP_CYCLES, 60: consecutive idle cycles that end a character (≥2, <2^16).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sym_in  in  2  classifier code: 00 wait, 01 dot, 10 dash, 11 send (level, may persist many cycles).
- key_down  in  1  raw button level; high freezes the gap counter.
- out_ready  in  1  downstream accepts the character this cycle.
- out_valid  out  1  out_code/out_len/out_word_end valid.
- out_code  out  MAX_SYMBOLS  bit i = symbol i (0 dot, 1 dash), first symbol in bit 0, unused bits 0.
- out_len  out  3  number of symbols, 0..MAX_SYMBOLS.
- out_word_end  out  1  character closed by send.
- out_overflow  out  1  symbols beyond MAX_SYMBOLS were discarded for this character.
- drop_pulse  out  1  one-cycle pulse when a dot/dash is discarded because the assembler is stalled.

## Operation
- Assembly registers: asm_code, asm_len, asm_ovf, gap_cnt (16 b), send_prev.
- Send event = sym_in==11 while send_prev==0 (rising edge); send_prev <= (sym_in==11) every cycle.
- States: IDLE, COLLECT, STALL.
- IDLE: dot/dash -> asm_code[0]=symbol, asm_len=1, gap_cnt=0, go COLLECT. Send event -> close an empty character (len 0, code 0, word_end 1). Wait -> stay.
- COLLECT: dot/dash with asm_len<MAX_SYMBOLS -> write bit asm_len, asm_len+1, gap_cnt=0. Dot/dash with asm_len==MAX_SYMBOLS -> asm_ovf=1, gap_cnt=0, symbol discarded. Wait with key_down=0 -> gap_cnt+1; wait with key_down=1 -> gap_cnt holds. gap_cnt reaching GAP_CYCLES-1 while incrementing -> close with word_end=0. Send event -> close with word_end=1 (overrides gap close same cycle).
- Close: if output register empty, or being emptied this cycle (out_valid & out_ready) -> load output register, clear assembly, go IDLE. Otherwise go STALL holding the pending character and its word_end.
- STALL: dot/dash -> discarded, drop_pulse=1. Send events ignored. On out_valid & out_ready -> pending character loads output register that same cycle, assembly cleared, go IDLE.
- Output register: out_valid set on load, cleared on transfer without a simultaneous load; fields stable while out_valid & !out_ready.
- asm_len never exceeds MAX_SYMBOLS; gap_cnt saturates, no wrap.

## Timing
- Reset (async, immediate): state IDLE, all assembly registers 0, send_prev 0, every output 0.
- Symbol capture: registered on the cycle sym_in shows 01/10.
- Gap close: out_valid rises the cycle after the GAP_CYCLES-th consecutive counted idle cycle following the last symbol.
- Send close: out_valid rises one cycle after the first cycle sym_in==11.
- Transfer and reload in the same cycle leave out_valid high with new fields next cycle; no bubble.
- Reset mid-character or with out_valid high: everything discarded, no partial output.

## Test plan
- Dot, dash, then 60 idle cycles, out_ready=1 -> out_valid one cycle, out_code=00010, out_len=2, word_end=0, overflow=0.
- Dash, then sym_in=11 held 10 cycles -> exactly one character, out_code=00001, out_len=1, word_end=1; no second send character.
- Six dots then gap -> out_len=5, out_code=00000, out_overflow=1.
- out_ready=0: char "A" closed, then "T" closed -> STALL; a further dot gives drop_pulse=1; raise out_ready -> A transferred, T presented next cycle, then IDLE.
- key_down high for 100 cycles between dot and dash in COLLECT -> no gap close; single character len 2 after final gap.
- Assert rst while COLLECT with len 3 and out_valid=1 -> all outputs 0 immediately; next dot starts a fresh len-1 character.
